// File: rtl/jt51_timer_ctrl_if.sv
// CPU write bus for the JT51 timer control stage: strobes, address select, data and status.
interface jt51_timer_ctrl_if;
   logic       cs_n;
   logic       wr_n;
   logic       a0;
   logic [7:0] din;
   logic [7:0] dout;
   logic       busy;

   modport master (output cs_n, output wr_n, output a0, output din, input dout, input busy);
   modport slave  (input cs_n, input wr_n, input a0, input din, output dout, output busy);
endinterface

// File: rtl/jt51_timer_ctrl.sv
// JT51 timer control: decodes CPU writes to 0x10/0x11/0x12/0x14, tracks write-busy,
// builds the status byte and, when JT51_CSM_EN is defined, the CSM key-on request.
module jt51_timer_ctrl #(
   parameter int BUSY_CNT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic             zero,
   jt51_timer_ctrl_if.slave bus,
   input  logic             flag_A,
   input  logic             flag_B,
   input  logic             overflow_A,
   output logic [9:0]       value_A,
   output logic [7:0]       value_B,
   output logic             load_A,
   output logic             load_B,
   output logic             clr_flag_A,
   output logic             clr_flag_B,
   output logic             enable_irq_A,
   output logic             enable_irq_B,
   output logic             csm_keyon
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } busy_state_t;

   localparam logic [6:0] BUSY_LOAD = 7'(BUSY_CNT);

   busy_state_t state_r;
   busy_state_t state_s;
   logic [6:0]  cnt_r;
   logic [6:0]  cnt_s;
   logic        we_s;
   logic        we_l_r;
   logic        accept_s;
   logic        data_ok_s;
   logic [7:0]  addr_r;
   logic [7:0]  dout_r;
   logic [9:0]  value_a_r;
   logic [7:0]  value_b_r;
   logic        load_a_r;
   logic        load_b_r;
   logic        clr_a_r;
   logic        clr_b_r;
   logic        irq_a_r;
   logic        irq_b_r;

   // Only the first edge of a low strobe counts, so a long strobe acts once.
   assign we_s      = ~bus.cs_n & ~bus.wr_n;
   assign accept_s  = we_s & ~we_l_r;
   assign data_ok_s = accept_s & bus.a0 & (state_r == ST_IDLE);

   // Strobe history and address latch; address writes are taken even while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_l_r <= 1'b0;
         addr_r <= 8'h00;
      end else begin
         we_l_r <= we_s;
         if (accept_s && !bus.a0) addr_r <= bus.din;
      end
   end

   // Busy state and countdown register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 7'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Busy next state: load on an accepted data write, count down on cen, drop at 1.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (data_ok_s) begin
               state_s = ST_BUSY;
               cnt_s   = BUSY_LOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cen) begin
               cnt_s = cnt_r - 7'd1;
               if (cnt_r == 7'd1) state_s = ST_IDLE;
               else               state_s = ST_BUSY;
            end else begin
               state_s = ST_BUSY;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 7'd0;
         end
      endcase
   end

   // Timer register file; flag clears are one-clk pulses independent of cen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_a_r <= 10'd0;
         value_b_r <= 8'd0;
         load_a_r  <= 1'b0;
         load_b_r  <= 1'b0;
         clr_a_r   <= 1'b0;
         clr_b_r   <= 1'b0;
         irq_a_r   <= 1'b0;
         irq_b_r   <= 1'b0;
      end else begin
         clr_a_r <= 1'b0;
         clr_b_r <= 1'b0;
         if (data_ok_s) begin
            case (addr_r)
               8'h10: value_a_r[9:2] <= bus.din;
               8'h11: value_a_r[1:0] <= bus.din[1:0];
               8'h12: value_b_r      <= bus.din;
               8'h14: begin
                  clr_b_r  <= bus.din[5];
                  clr_a_r  <= bus.din[4];
                  irq_b_r  <= bus.din[3];
                  irq_a_r  <= bus.din[2];
                  load_b_r <= bus.din[1];
                  load_a_r <= bus.din[0];
               end
               default: ;
            endcase
         end
      end
   end

   // Status byte, one clk behind busy and the timer flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) dout_r <= 8'h00;
      else     dout_r <= {state_r == ST_BUSY, 5'b00000, flag_B, flag_A};
   end

`ifdef JT51_CSM_EN
   logic csm_r;
   logic keyon_r;

   // Key-on is re-evaluated every zero tick; csm_r is read before a same-edge 0x14 write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csm_r   <= 1'b0;
         keyon_r <= 1'b0;
      end else begin
         if (cen && zero) keyon_r <= overflow_A & csm_r;
         if (data_ok_s && (addr_r == 8'h14)) csm_r <= bus.din[7];
      end
   end

   assign csm_keyon = keyon_r;
`else
   logic unused_csm_s;

   assign unused_csm_s = &{1'b0, zero, overflow_A};
   assign csm_keyon    = 1'b0;
`endif

   assign bus.busy     = (state_r == ST_BUSY);
   assign bus.dout     = dout_r;
   assign value_A      = value_a_r;
   assign value_B      = value_b_r;
   assign load_A       = load_a_r;
   assign load_B       = load_b_r;
   assign clr_flag_A   = clr_a_r;
   assign clr_flag_B   = clr_b_r;
   assign enable_irq_A = irq_a_r;
   assign enable_irq_B = irq_b_r;

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
// Directed bench for jt51_timer_ctrl (BUSY_CNT=64, cen every 2 clk); CSM expectations follow JT51_CSM_EN.
module tb_jt51_timer_ctrl;

`ifdef JT51_CSM_EN
   localparam logic CSM_ON = 1'b1;
`else
   localparam logic CSM_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b0;
   logic       zero = 1'b0;
   logic       flag_A = 1'b0;
   logic       flag_B = 1'b0;
   logic       overflow_A = 1'b0;
   logic [9:0] value_A;
   logic [7:0] value_B;
   logic       load_A, load_B, clr_flag_A, clr_flag_B;
   logic       enable_irq_A, enable_irq_B, csm_keyon;

   logic       cen_auto = 1'b1;
   int         cen_ticks = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   jt51_timer_ctrl_if bus ();

   jt51_timer_ctrl #(.BUSY_CNT(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .cen          (cen),
      .zero         (zero),
      .bus          (bus),
      .flag_A       (flag_A),
      .flag_B       (flag_B),
      .overflow_A   (overflow_A),
      .value_A      (value_A),
      .value_B      (value_B),
      .load_A       (load_A),
      .load_B       (load_B),
      .clr_flag_A   (clr_flag_A),
      .clr_flag_B   (clr_flag_B),
      .enable_irq_A (enable_irq_A),
      .enable_irq_B (enable_irq_B),
      .csm_keyon    (csm_keyon)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clk edge; inputs change 1 ns after it, outputs are sampled there too.
   task automatic step();
      if (cen === 1'b1) cen_ticks++;
      @(posedge clk);
      #1;
      if (cen_auto) cen = ~cen;
   endtask

   // Idle gap so the strobe is seen high, then one strobe edge; returns just after the accepting edge.
   task automatic cpu_write(input logic a0v, input logic [7:0] d);
      bus.cs_n = 1'b1;
      bus.wr_n = 1'b1;
      step();
      bus.cs_n = 1'b0;
      bus.wr_n = 1'b0;
      bus.a0   = a0v;
      bus.din  = d;
      step();
      bus.cs_n = 1'b1;
      bus.wr_n = 1'b1;
   endtask

   task automatic wait_busy_low(input string tag);
      int   n = 0;
      int   lag_err = 0;
      logic prev;
      while (bus.busy === 1'b1 && n < 400) begin
         prev = bus.busy;
         step();
         n++;
         if (bus.dout[7] !== prev) lag_err++;
      end
      chk({tag, "_busy_fell"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_dout7_lag"}, lag_err, 32'd0);
      step();
      chk({tag, "_dout7_low"}, {31'd0, bus.dout[7]}, 32'd0);
   endtask

   initial begin
      bus.cs_n = 1'b1;
      bus.wr_n = 1'b1;
      bus.a0   = 1'b0;
      bus.din  = 8'h00;

      #2;
      chk("reset_outputs", {value_A, value_B, load_A, load_B, clr_flag_A, clr_flag_B,
                            enable_irq_A, enable_irq_B, csm_keyon, bus.busy}, 32'd0);
      chk("reset_dout", {24'd0, bus.dout}, 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // value_A built from 0x10 then 0x11
      cpu_write(1'b0, 8'h10);
      cpu_write(1'b1, 8'hC8);
      chk("busy_after_wr10", {31'd0, bus.busy}, 32'd1);
      chk("value_A_hi", {22'd0, value_A}, 32'h320);
      chk("dout7_same_clk", {31'd0, bus.dout[7]}, 32'd0);
      wait_busy_low("wr10");
      cpu_write(1'b0, 8'h11);
      cpu_write(1'b1, 8'h03);
      chk("value_A_full", {22'd0, value_A}, 32'h323);
      wait_busy_low("wr11");

      // value_B and exact busy length in cen ticks
      cpu_write(1'b0, 8'h12);
      cpu_write(1'b1, 8'h5A);
      cen_ticks = 0;
      chk("value_B_5A", {24'd0, value_B}, 32'h5A);
      wait_busy_low("wr12");
      chk("busy_len_64", cen_ticks - ((cen === 1'b0) ? 1 : 0), 32'd64);

      // Data write while busy is dropped and does not restart the count
      cpu_write(1'b1, 8'h66);
      cen_ticks = 0;
      repeat (10) step();
      cpu_write(1'b1, 8'h11);
      chk("drop_while_busy", {24'd0, value_B}, 32'h66);
      wait_busy_low("drop");
      chk("busy_len_orig", cen_ticks - ((cen === 1'b0) ? 1 : 0), 32'd64);

      // Long address strobe latches only the first din
      bus.cs_n = 1'b0;
      bus.wr_n = 1'b0;
      bus.a0   = 1'b0;
      bus.din  = 8'h12;
      step();
      bus.din  = 8'h10;
      step();
      step();
      cpu_write(1'b1, 8'h77);
      chk("long_strobe_B", {24'd0, value_B}, 32'h77);
      chk("long_strobe_A", {22'd0, value_A}, 32'h323);
      wait_busy_low("long");

      // Unmapped address still starts busy but changes nothing
      cpu_write(1'b0, 8'h13);
      cpu_write(1'b1, 8'hFF);
      chk("unmapped_busy", {31'd0, bus.busy}, 32'd1);
      chk("unmapped_regs", {value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B},
          {10'h323, 8'h77, 4'b0000});
      wait_busy_low("unmapped");

      // 0x14 with 0x3F: levels set, clears pulse for one clk
      cpu_write(1'b0, 8'h14);
      cpu_write(1'b1, 8'h3F);
      chk("ctl_levels", {28'd0, load_A, load_B, enable_irq_A, enable_irq_B}, 32'hF);
      chk("clr_pulse_on", {30'd0, clr_flag_A, clr_flag_B}, 32'd3);
      step();
      chk("clr_pulse_off", {30'd0, clr_flag_A, clr_flag_B}, 32'd0);
      chk("ctl_levels_hold", {28'd0, load_A, load_B, enable_irq_A, enable_irq_B}, 32'hF);

      // Status flags appear in dout one clk later
      flag_A = 1'b1;
      step();
      chk("dout_flagA", {30'd0, bus.dout[1:0]}, 32'd1);
      flag_A = 1'b0;
      flag_B = 1'b1;
      step();
      chk("dout_flagB", {30'd0, bus.dout[1:0]}, 32'd2);
      chk("dout_zero_bits", {27'd0, bus.dout[6:2]}, 32'd0);
      flag_B = 1'b0;
      wait_busy_low("ctl3F");

      // CSM key-on from timer A overflow
      cpu_write(1'b1, 8'h81);
      chk("ctl81_levels", {28'd0, load_A, load_B, enable_irq_A, enable_irq_B}, 32'h8);
      cen_auto = 1'b0;
      cen = 1'b0;
      step();
      chk("keyon_idle", {31'd0, csm_keyon}, 32'd0);
      cen = 1'b1;
      zero = 1'b1;
      overflow_A = 1'b1;
      step();
      chk("keyon_set", {31'd0, csm_keyon}, {31'd0, CSM_ON});
      cen = 1'b0;
      overflow_A = 1'b0;
      step();
      step();
      chk("keyon_hold", {31'd0, csm_keyon}, {31'd0, CSM_ON});
      cen = 1'b1;
      step();
      chk("keyon_clear", {31'd0, csm_keyon}, 32'd0);
      zero = 1'b0;
      cen = 1'b0;
      cen_auto = 1'b1;
      wait_busy_low("ctl81");

      // Asynchronous reset mid-busy
      cpu_write(1'b1, 8'h01);
      step();
      step();
      chk("pre_rst_state", {29'd0, bus.busy, load_A, bus.dout[7]}, 32'd7);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst", {29'd0, bus.busy, load_A, (bus.dout != 8'h00)}, 32'd0);
      chk("async_rst_vals", {12'd0, value_A, value_B, 2'b00}, 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("post_rst_idle", {31'd0, bus.busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
